// File: rtl/core_pkg.sv
// Shared types and constants for the multi-cycle core's memory subsystem.
package core_pkg;

    localparam int unsigned MEM_ADDR_W = 10;
    localparam int unsigned WORD_W     = 32;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_D    = 2'd2
    } owner_e;

endpackage

// File: rtl/mem_resp_pipe.sv
// Two-stage owner-tag shift register that steers synchronous memory read data
// back to the fetch or load/store requester.
module mem_resp_pipe
    import core_pkg::*;
#(
    parameter int unsigned DATA_W = WORD_W
) (
    input  logic              clk,
    input  logic              rst,
    input  owner_e            own_in,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata
);

    owner_e            own1_q, own2_q;
    logic [DATA_W-1:0] if_hold_q, d_hold_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            own1_q    <= OWN_NONE;
            own2_q    <= OWN_NONE;
            if_hold_q <= '0;
            d_hold_q  <= '0;
        end else begin
            own1_q    <= own_in;
            own2_q    <= own1_q;
            if_hold_q <= if_rdata;
            d_hold_q  <= d_rdata;
        end
    end

    // The owning bus passes mem_rdata through on its valid cycle and the hold
    // register keeps it afterwards; the other bus is left untouched.
    always_comb begin
        if_rvalid = (own2_q == OWN_IF);
        d_rvalid  = (own2_q == OWN_D);
        if_rdata  = if_rvalid ? mem_rdata : if_hold_q;
        d_rdata   = d_rvalid  ? mem_rdata : d_hold_q;
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between instruction fetch and load/store: data has
// priority, a bounded data-run counter guarantees fetch progress.
module mem_port_arbiter
    import core_pkg::*;
#(
    parameter int unsigned ADDR_W   = MEM_ADDR_W,
    parameter int unsigned DATA_W   = WORD_W,
    parameter int unsigned MAX_DRUN = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int unsigned       DRUN_W   = $clog2(MAX_DRUN + 1);
    localparam logic [DRUN_W-1:0] DRUN_MAX = DRUN_W'(MAX_DRUN);

    logic [DRUN_W-1:0] drun_q, drun_d;
    owner_e            own_next;

    always_comb begin
        d_gnt    = d_req && !(if_req && (drun_q == DRUN_MAX));
        if_gnt   = if_req && !d_gnt;
        drun_d   = drun_q;
        own_next = OWN_NONE;
        // Only data grants taken while a fetch is waiting count toward the run.
        if (!if_req || if_gnt) begin
            drun_d = '0;
        end else if (d_gnt && (drun_q != DRUN_MAX)) begin
            drun_d = drun_q + 1'b1;
        end
        if (d_gnt && !d_we) begin
            own_next = OWN_D;
        end else if (if_gnt) begin
            own_next = OWN_IF;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drun_q    <= '0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            drun_q <= drun_d;
            mem_en <= d_gnt || if_gnt;
            mem_we <= d_gnt && d_we;
            if (d_gnt) begin
                mem_addr  <= d_addr;
                mem_wdata <= d_wdata;
            end else if (if_gnt) begin
                mem_addr  <= if_addr;
                mem_wdata <= '0;
            end
        end
    end

    mem_resp_pipe #(
        .DATA_W (DATA_W)
    ) u_resp_pipe (
        .clk       (clk),
        .rst       (rst),
        .own_in    (own_next),
        .mem_rdata (mem_rdata),
        .if_rvalid (if_rvalid),
        .if_rdata  (if_rdata),
        .d_rvalid  (d_rvalid),
        .d_rdata   (d_rdata)
    );

endmodule
